// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline register: occupancy state
// encoding and default bubble payload.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int          OCC_W          = 2;
    localparam int          DEFAULT_WIDTH  = 32;
    localparam logic [31:0] DEFAULT_NOP    = 32'h0000_0000;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: adds a small increment when enabled and sticks at
// the all-ones value instead of wrapping.
module pipe_skid_reg_sat_counter #(
    parameter int CNT_W = 8,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        if (sum[CNT_W])
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_p1 <= '0;
        else if (en)
            cnt_p1 <= sat_add(cnt_p1, inc);
    end

    assign cnt = cnt_p1;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with registered ready, flush and a
// saturating count of entries discarded by flush.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] drop_cnt
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_p1, main_d;
    logic [WIDTH-1:0] skid_p1, skid_d;
    logic             in_ready_p1, in_ready_d;
    logic             in_fire, out_fire;
    logic [1:0]       drop_inc;

    assign in_fire  = in_valid & in_ready_p1;
    assign out_fire = out_valid & out_ready & ~stall;

    // ---- stage p1: state and ready registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_p1 <= 1'b1;
        end else begin
            state_q     <= state_d;
            in_ready_p1 <= in_ready_d;
        end
    end

    // Bubbles are reloaded on every vacate so a stale payload never shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1 <= NOP_VAL;
            skid_p1 <= NOP_VAL;
        end else begin
            main_p1 <= main_d;
            skid_p1 <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_p1;
        skid_d  = skid_p1;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VAL;
                    end
                    2'b11: main_d = in_data;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_p1;
                    skid_d  = NOP_VAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = NOP_VAL;
                skid_d  = NOP_VAL;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
        end
        // Depends only on next state, so out_ready/stall never reach in_ready combinationally.
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        occ       = occ_of(state_q);
    end

    assign in_ready = in_ready_p1;
    assign out_data = main_p1;
    assign drop_inc = occ + {1'b0, in_fire};

    pipe_skid_reg_sat_counter #(
        .CNT_W(CNT_W),
        .INC_W(2)
    ) u_drop_cnt (
        .clk(clk),
        .rst(rst),
        .en (flush),
        .inc(drop_inc),
        .cnt(drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed, table-driven bench for pipe_skid_reg; a second instance with a
// 2-bit drop counter shares the stimulus to exercise saturation.
module tb_pipe_skid_reg;

    localparam int         W   = 8;
    localparam logic [7:0] NOP = 8'hC3;

    logic       clk = 1'b0;
    logic       rst, flush, stall, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] occ;
    logic [7:0] drop_cnt;
    logic       in_ready2, out_valid2;
    logic [7:0] out_data2;
    logic [1:0] occ2;
    logic [1:0] drop_cnt2;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .NOP_VAL(NOP), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occ(occ), .drop_cnt(drop_cnt)
    );

    pipe_skid_reg #(.WIDTH(W), .NOP_VAL(NOP), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occ(occ2), .drop_cnt(drop_cnt2)
    );

    typedef struct {
        logic       fl;
        logic       st;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] occ;
        logic       ir;
        int         drop;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [7:0] od,
                              input logic [1:0] oc, input logic ir, input int drop);
        int drop2;
        drop2 = (drop > 3) ? 3 : drop;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " out_data"},  32'(out_data),  32'(od));
        chk({tag, " occ"},       32'(occ),       32'(oc));
        chk({tag, " in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, " drop_cnt"},  32'(drop_cnt),  32'(drop));
        chk({tag, " drop_cnt2"}, 32'(drop_cnt2), 32'(drop2));
        chk({tag, " out_data2"}, 32'(out_data2), 32'(od));
    endtask

    task automatic add(input logic fl, input logic st, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic ov, input logic [7:0] od,
                       input logic [1:0] oc, input logic ir, input int drop);
        vec_t v;
        v.fl = fl; v.st = st; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.occ = oc; v.ir = ir; v.drop = drop;
        vecs.push_back(v);
    endtask

    task automatic step(input string tag, input vec_t v);
        flush = v.fl; stall = v.st; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
        @(posedge clk);
        #1;
        check_outs(tag, v.ov, v.od, v.occ, v.ir, v.drop);
    endtask

    initial begin
        vec_t v;
        int   d;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, NOP, 2'd0, 1'b1, 0);

        // streaming: one per cycle, 1-cycle latency, never FULL
        for (int i = 1; i <= 16; i++)
            add(0, 0, 1, 8'(i), 1, 1, 8'(i), 2'd1, 1, 0);
        add(0, 0, 0, 8'h00, 1, 0, NOP, 2'd0, 1, 0);
        // fill to FULL, upstream data ignored while FULL, drain in order
        add(0, 0, 1, 8'h11, 0, 1, 8'h11, 2'd1, 1, 0);
        add(0, 0, 1, 8'h22, 0, 1, 8'h11, 2'd2, 0, 0);
        add(0, 0, 1, 8'hEE, 0, 1, 8'h11, 2'd2, 0, 0);
        add(0, 0, 1, 8'hEE, 1, 1, 8'h22, 2'd1, 1, 0);
        add(0, 0, 0, 8'h00, 1, 0, NOP, 2'd0, 1, 0);
        // FULL flush with in_ready low, then ONE flush with in_fire
        d = 0;
        add(0, 0, 1, 8'h44, 0, 1, 8'h44, 2'd1, 1, d);
        add(0, 0, 1, 8'h55, 0, 1, 8'h44, 2'd2, 0, d);
        d += 2;
        add(1, 0, 1, 8'h66, 0, 0, NOP, 2'd0, 1, d);
        add(0, 0, 1, 8'h77, 0, 1, 8'h77, 2'd1, 1, d);
        d += 2;
        add(1, 0, 1, 8'h88, 1, 0, NOP, 2'd0, 1, d);
        // three more FULL flushes; the 2-bit counter stays at 3
        for (int k = 0; k < 3; k++) begin
            add(0, 0, 1, 8'h90 + 8'(k), 0, 1, 8'h90 + 8'(k), 2'd1, 1, d);
            add(0, 0, 1, 8'hA0 + 8'(k), 0, 1, 8'h90 + 8'(k), 2'd2, 0, d);
            d += 2;
            add(1, 0, 1, 8'hB0, 1, 0, NOP, 2'd0, 1, d);
        end
        // stall holds output; pushes still accepted until FULL
        add(0, 1, 1, 8'h33, 1, 1, 8'h33, 2'd1, 1, d);
        add(0, 1, 0, 8'h00, 1, 1, 8'h33, 2'd1, 1, d);
        add(0, 1, 0, 8'h00, 1, 1, 8'h33, 2'd1, 1, d);
        add(0, 1, 1, 8'h34, 1, 1, 8'h33, 2'd2, 0, d);
        add(0, 0, 0, 8'h00, 1, 1, 8'h34, 2'd1, 1, d);
        add(0, 0, 0, 8'h00, 1, 0, NOP, 2'd0, 1, d);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // asynchronous reset while FULL takes effect before the next edge
        v.fl = 0; v.st = 0; v.iv = 1; v.id = 8'hA5; v.ordy = 0;
        v.ov = 1; v.od = 8'hA5; v.occ = 2'd1; v.ir = 1; v.drop = d;
        step("fillA5", v);
        v.id = 8'h5A; v.occ = 2'd2; v.ir = 0;
        step("fill5A", v);
        #2;
        rst = 1'b1;
        #1;
        check_outs("rst_mid_full", 1'b0, NOP, 2'd0, 1'b1, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        v.id = 8'h3C; v.ov = 1; v.od = 8'h3C; v.occ = 2'd1; v.ir = 1; v.drop = 0;
        step("first_after_rst", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload bit width (1..512).
REQ-002 Parameter NOP_VAL, default all-zero, payload value loaded on reset, flush and drain (bubble).
REQ-003 Parameter CNT_W, default 8, width of flush-drop counter.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline flush, discard all held and incoming entries.
REQ-007 stall  input  1  downstream stall, blocks output consumption like out_ready=0.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  registered, block can accept an entry this cycle.
REQ-010 in_data  input  WIDTH  upstream payload.
REQ-011 out_valid  output  1  out_data holds a live entry.
REQ-012 out_ready  input  1  downstream accepts entry.
REQ-013 out_data  output  WIDTH  registered payload to next stage.
REQ-014 occ  output  2  entries held (0..2).
REQ-015 drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~stall.
REQ-017 States EMPTY (occ=0), ONE (occ=1), FULL (occ=2); storage = main register (drives out_data) + skid register.
REQ-018 EMPTY: in_fire -> ONE, main<=in_data; else stay.
REQ-019 ONE: in_fire & ~out_fire -> FULL, skid<=in_data; ~in_fire & out_fire -> EMPTY, main<=NOP_VAL; both -> ONE, main<=in_data; neither -> hold.
REQ-020 FULL: out_fire -> ONE, main<=skid, skid<=NOP_VAL; else hold; in_fire cannot occur.
REQ-021 in_ready registered: next value 1 unless next state FULL; no combinational path from out_ready/stall to in_ready.
REQ-022 out_valid = (state != EMPTY); out_data = main register, never combinational from in_data.
REQ-023 Latency: entry accepted in cycle N visible on out_data in cycle N+1 when block EMPTY or ONE-with-out_fire.
REQ-024 Throughput: sustained one entry per cycle with out_ready=1, stall=0; order strictly FIFO, no loss, no duplication.
REQ-025 flush highest priority: next state EMPTY, main and skid <= NOP_VAL, in_ready<=1, in_fire and out_fire in same cycle ignored (entry not consumed upstream-visible-wise is block's concern only: in_data dropped).
REQ-026 On flush, drop_cnt += occ + (in_valid & in_ready), saturating at 2^CNT_W-1; no wrap.
REQ-027 stall=1 with any out_ready: state and payload held, in_fire still allowed while not FULL.
REQ-028 Payload bits beyond live entry never leak: EMPTY implies out_data == NOP_VAL.

Reset
REQ-029 rst asserted (any time, including mid-transfer): state EMPTY, main=skid=NOP_VAL, out_valid=0, occ=0, in_ready=1, drop_cnt=0, effective immediately.
REQ-030 First in_fire possible in first clk edge after rst deasserts.

Structure
REQ-031 State encoding (EMPTY/ONE/FULL) and default NOP payload constants belong in shared package defines.v alongside ALU_NOP/ZeroWord.
REQ-032 One sub-module natural: sat_counter (parametrised width, increment-by-n, saturating) for drop_cnt.
REQ-033 Stage payloads (e.g. MEM/WB bundle) concatenated by instantiating stage; block payload-agnostic.

Verification
REQ-034 Reset mid-FULL (main=0xA5, skid=0x5A) -> same cycle out_valid=0, out_data=NOP_VAL, in_ready=1, occ=0.
REQ-035 Stream 0x01..0x10, out_ready=1, stall=0 -> 16 outputs in order, one per cycle, 1-cycle latency, occ never 2.
REQ-036 Push 0x11,0x22 with out_ready=0 -> occ=2, in_ready=0 next cycle; release -> 0x11 then 0x22, then EMPTY with out_data=NOP_VAL.
REQ-037 FULL plus flush with in_valid=1 -> next cycle EMPTY, drop_cnt=2 (in_ready was 0); ONE plus flush with in_fire -> drop_cnt +=2.
REQ-038 CNT_W=2, four FULL flushes -> drop_cnt saturates at 3.
REQ-039 stall=1, out_ready=1, push 0x33 -> held at out_data while stall high, consumed first cycle stall=0.
